// File: rtl/carry_skip_pkg.sv
// Shared types and sizing helpers for the iterative carry-skip adder.
// Optional overflow output is controlled by CARRY_SKIP_OVERFLOW_EN.
package carry_skip_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int num_blocks(input int n, input int b);
      return n / b;
   endfunction

   function automatic int skip_cnt_width(input int n, input int b);
      return $clog2((n / b) + 1);
   endfunction

endpackage

// File: rtl/iterative_carry_skip_adder_if.sv
// Operand/result handshake bundle of the iterative carry-skip adder.
// The overflow signal exists only when CARRY_SKIP_OVERFLOW_EN is defined.
interface iterative_carry_skip_adder_if
   import carry_skip_pkg::*;
#(
   parameter int N = 32,
   parameter int B = 8
);
   localparam int SW = skip_cnt_width(N, B);

   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  a;
   logic [N-1:0]  b;
   logic          carry_in;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  c;
   logic          carry_out;
   logic [SW-1:0] skip_count;
`ifdef CARRY_SKIP_OVERFLOW_EN
   logic          overflow;

   modport master (
      output in_valid, a, b, carry_in, out_ready,
      input  in_ready, out_valid, c, carry_out, skip_count, overflow
   );
   modport slave (
      input  in_valid, a, b, carry_in, out_ready,
      output in_ready, out_valid, c, carry_out, skip_count, overflow
   );
`else
   modport master (
      output in_valid, a, b, carry_in, out_ready,
      input  in_ready, out_valid, c, carry_out, skip_count
   );
   modport slave (
      input  in_valid, a, b, carry_in, out_ready,
      output in_ready, out_valid, c, carry_out, skip_count
   );
`endif

endinterface

// File: rtl/carry_skip_block.sv
// One B-bit ripple-carry block with all-propagate detection and skip mux.
module carry_skip_block #(
   parameter int B = 8
) (
   input  logic [B-1:0] a,
   input  logic [B-1:0] b,
   input  logic         carry_in,
   output logic [B-1:0] sum,
   output logic         carry_out,
   output logic         skipped
);
   logic [B-1:0] p_s;
   logic [B-1:0] g_s;
   logic         ripple_s;

   // Ripple chain plus bypass when every bit propagates.
   always_comb begin
      p_s      = a ^ b;
      g_s      = a & b;
      ripple_s = carry_in;
      sum      = '0;
      for (int i = 0; i < B; i++) begin
         sum[i]   = p_s[i] ^ ripple_s;
         ripple_s = g_s[i] | (p_s[i] & ripple_s);
      end
      skipped   = &p_s;
      carry_out = skipped ? carry_in : ripple_s;
   end

endmodule

// File: rtl/iterative_carry_skip_adder.sv
// Iterative carry-skip adder: one B-bit block per cycle, LSB block first.
// Define CARRY_SKIP_OVERFLOW_EN to add the registered signed-overflow output.
module iterative_carry_skip_adder
   import carry_skip_pkg::*;
#(
   parameter int N = 32,
   parameter int B = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   iterative_carry_skip_adder_if.slave bus
);
   localparam int K  = num_blocks(N, B);
   localparam int SW = skip_cnt_width(N, B);
   localparam int IW = (K > 1) ? $clog2(K) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

   state_e        state_r;
   state_e        state_next_s;
   logic [N-1:0]  a_sh_r;
   logic [N-1:0]  b_sh_r;
   logic [N-1:0]  sum_r;
   logic          carry_r;
   logic [IW-1:0] idx_r;
   logic [SW-1:0] skip_acc_r;
   logic [N-1:0]  c_r;
   logic          carry_out_r;
   logic [SW-1:0] skip_count_r;

   logic [B-1:0]  blk_sum_s;
   logic          blk_cout_s;
   logic          blk_skip_s;
   logic [N-1:0]  blk_ext_s;
   logic [N-1:0]  sum_next_s;
   logic [SW-1:0] skip_next_s;
   logic          accept_s;
   logic          last_s;
   logic          finish_s;

   carry_skip_block #(.B(B)) u_block (
      .a         (a_sh_r[B-1:0]),
      .b         (b_sh_r[B-1:0]),
      .carry_in  (carry_r),
      .sum       (blk_sum_s),
      .carry_out (blk_cout_s),
      .skipped   (blk_skip_s)
   );

   // Control qualifiers and the next partial sum shifted in from the top.
   always_comb begin
      accept_s    = (state_r == IDLE) && bus.in_valid && !reset;
      last_s      = (idx_r == LAST_IDX);
      finish_s    = (state_r == BUSY) && last_s;
      blk_ext_s   = '0;
      blk_ext_s[B-1:0] = blk_sum_s;
      sum_next_s  = (sum_r >> B) | (blk_ext_s << (N - B));
      skip_next_s = skip_acc_r + SW'(blk_skip_s);
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.in_valid) state_next_s = BUSY;
            else              state_next_s = IDLE;
         end
         BUSY: begin
            if (last_s) state_next_s = DONE;
            else        state_next_s = BUSY;
         end
         DONE: begin
            if (bus.out_ready) state_next_s = IDLE;
            else               state_next_s = DONE;
         end
         default: state_next_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state_r <= IDLE;
      else       state_r <= state_next_s;
   end

   // Operand shift registers, carry, block index and skip accumulator.
   always_ff @(posedge clock) begin
      if (reset) begin
         a_sh_r     <= '0;
         b_sh_r     <= '0;
         sum_r      <= '0;
         carry_r    <= 1'b0;
         idx_r      <= '0;
         skip_acc_r <= '0;
      end else if (accept_s) begin
         a_sh_r     <= bus.a;
         b_sh_r     <= bus.b;
         sum_r      <= '0;
         carry_r    <= bus.carry_in;
         idx_r      <= '0;
         skip_acc_r <= '0;
      end else if (state_r == BUSY) begin
         a_sh_r     <= a_sh_r >> B;
         b_sh_r     <= b_sh_r >> B;
         sum_r      <= sum_next_s;
         carry_r    <= blk_cout_s;
         idx_r      <= idx_r + IW'(1);
         skip_acc_r <= skip_next_s;
      end
   end

   // Result registers, loaded only when the last block completes.
   always_ff @(posedge clock) begin
      if (reset) begin
         c_r          <= '0;
         carry_out_r  <= 1'b0;
         skip_count_r <= '0;
      end else if (finish_s) begin
         c_r          <= sum_next_s;
         carry_out_r  <= blk_cout_s;
         skip_count_r <= skip_next_s;
      end
   end

`ifdef CARRY_SKIP_OVERFLOW_EN
   logic overflow_r;

   // Carry into the MSB is recovered from the MSB sum bit and its operands.
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow_r <= 1'b0;
      end else if (finish_s) begin
         overflow_r <= blk_sum_s[B-1] ^ a_sh_r[B-1] ^ b_sh_r[B-1] ^ blk_cout_s;
      end
   end

   assign bus.overflow = overflow_r;
`endif

   assign bus.in_ready   = (state_r == IDLE) && !reset;
   assign bus.out_valid  = (state_r == DONE);
   assign bus.c          = c_r;
   assign bus.carry_out  = carry_out_r;
   assign bus.skip_count = skip_count_r;

endmodule
